// File: rtl/axis_memif_pkg.sv
// Shared opcodes, word widths and field offsets for the GTP command decoder / comparator.
package axis_memif_pkg;

  localparam int OPC_W = 8;

  localparam logic [7:0] OPC_WR  = 8'h02;
  localparam logic [7:0] OPC_RD  = 8'h03;
  localparam logic [7:0] OPC_INJ = 8'h80;
  localparam logic [7:0] OPC_CLR = 8'hC0;

  function automatic int cmd_w(input int aw, input int dw);
    return OPC_W + aw + dw;
  endfunction

  function automatic int rsp_w(input int aw, input int dw);
    return OPC_W + aw + 2 * dw;
  endfunction

  // Command word {opcode, addr, wdata}: LSB position of each field
  localparam int CMD_WDATA_LSB = 0;
  function automatic int cmd_addr_lsb(input int dw);
    return dw;
  endfunction
  function automatic int cmd_opc_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

  // Response word {7'b0, mismatch, addr, dut_data, model_data}
  localparam int RSP_MODEL_LSB = 0;
  function automatic int rsp_dut_lsb(input int dw);
    return dw;
  endfunction
  function automatic int rsp_addr_lsb(input int dw);
    return 2 * dw;
  endfunction
  function automatic int rsp_mis_bit(input int aw, input int dw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/axis_memif_cmp_if.sv
// Command/response streams plus the DUT and reference-model memory ports.
interface axis_memif_cmp_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    import axis_memif_pkg::*;

    localparam int CMD_W = cmd_w(ADDR_W, DATA_W);
    localparam int RSP_W = rsp_w(ADDR_W, DATA_W);

    // Both streams transfer exactly on a cycle with tvalid & tready; once tvalid is high
    // the source holds tdata/tlast stable until that transfer, and tvalid never waits on tready.
    logic [CMD_W-1:0]  gtp2core_tdata;
    logic              gtp2core_tvalid;
    logic              gtp2core_tready;
    logic              gtp2core_tlast;
    logic [RSP_W-1:0]  core2gtp_tdata;
    logic              core2gtp_tvalid;
    logic              core2gtp_tready;
    logic              core2gtp_tlast;

    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              ena_model;
    logic              wea_model;
    logic [ADDR_W-1:0] addra_model;
    logic [DATA_W-1:0] dina_model;
    logic [DATA_W-1:0] douta_model;

    modport slave (
        input  gtp2core_tdata, gtp2core_tvalid, gtp2core_tlast,
        output gtp2core_tready,
        output core2gtp_tdata, core2gtp_tvalid, core2gtp_tlast,
        input  core2gtp_tready,
        output ena, wea, addra, dina,
        input  douta,
        output ena_model, wea_model, addra_model, dina_model,
        input  douta_model
    );

    modport master (
        output gtp2core_tdata, gtp2core_tvalid, gtp2core_tlast,
        input  gtp2core_tready,
        input  core2gtp_tdata, core2gtp_tvalid, core2gtp_tlast,
        output core2gtp_tready,
        input  ena, wea, addra, dina,
        output douta,
        input  ena_model, wea_model, addra_model, dina_model,
        output douta_model
    );

endinterface

// File: rtl/axis_rsp_fifo.sv
// Synchronous response FIFO with a registered AXI-stream head; count includes the head register.
module axis_rsp_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             pop;
    logic             load;

    assign pop      = m_tvalid && m_tready;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign load     = (mem_cnt != '0) && (!m_tvalid || pop);
    assign count    = mem_cnt + (AW + 1)'(m_tvalid);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                m_tdata  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                m_tvalid <= 1'b1;
            end else if (pop) begin
                m_tvalid <= 1'b0;
            end
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + (AW + 1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW + 1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/axis_memif_cmp.sv
// Decodes GTP command words into DUT/model memory accesses, compares dual reads and
// returns tagged responses through a credit-protected FIFO.
module axis_memif_cmp
    import axis_memif_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             core_clk,
    input  logic             rst,
    axis_memif_cmp_if.slave  bus,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] bad_cmd_cnt
);
    localparam int RSP_W    = rsp_w(ADDR_W, DATA_W);
    localparam int NSTG     = RD_LAT + 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int OPC_LSB  = cmd_opc_lsb(ADDR_W, DATA_W);
    localparam int ADDR_LSB = cmd_addr_lsb(DATA_W);

    logic [7:0]        opc;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              accept;
    logic              is_wr, is_rd, is_inj, is_clr, is_bad;

    assign opc       = bus.gtp2core_tdata[OPC_LSB +: OPC_W];
    assign cmd_addr  = bus.gtp2core_tdata[ADDR_LSB +: ADDR_W];
    assign cmd_wdata = bus.gtp2core_tdata[CMD_WDATA_LSB +: DATA_W];
    assign accept    = bus.gtp2core_tvalid && bus.gtp2core_tready;
    assign is_wr     = (opc == OPC_WR);
    assign is_rd     = (opc == OPC_RD);
    assign is_inj    = (opc == OPC_INJ);
    assign is_clr    = (opc == OPC_CLR);
    assign is_bad    = !(is_wr || is_rd || is_inj || is_clr);

    // Memory ports pulse for exactly one cycle per accepted command, otherwise idle at 0.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            bus.ena         <= 1'b0;
            bus.wea         <= 1'b0;
            bus.addra       <= '0;
            bus.dina        <= '0;
            bus.ena_model   <= 1'b0;
            bus.wea_model   <= 1'b0;
            bus.addra_model <= '0;
            bus.dina_model  <= '0;
        end else begin
            bus.ena         <= accept && (is_wr || is_rd);
            bus.wea         <= accept && is_wr;
            bus.addra       <= (accept && (is_wr || is_rd)) ? cmd_addr : '0;
            bus.dina        <= (accept && is_wr) ? cmd_wdata : '0;
            bus.ena_model   <= accept && (is_inj || is_rd);
            bus.wea_model   <= accept && is_inj;
            bus.addra_model <= (accept && (is_inj || is_rd)) ? cmd_addr : '0;
            bus.dina_model  <= (accept && is_inj) ? cmd_wdata : '0;
        end
    end

    logic [NSTG-1:0]   pipe_v;
    logic [NSTG-1:0]   pipe_last;
    logic [ADDR_W-1:0] pipe_addr [NSTG];

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            for (int i = 0; i < NSTG; i++) pipe_addr[i] <= '0;
        end else begin
            pipe_v[0]    <= accept && is_rd;
            pipe_last[0] <= bus.gtp2core_tlast;
            pipe_addr[0] <= cmd_addr;
            for (int i = 1; i < NSTG; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    logic             rsp_push;
    logic             mis;
    logic [RSP_W-1:0] rsp_word;

    assign rsp_push = pipe_v[RD_LAT];
    assign mis      = (bus.douta != bus.douta_model);

    always_comb begin
        rsp_word = '0;
        rsp_word[RSP_MODEL_LSB +: DATA_W]         = bus.douta_model;
        rsp_word[rsp_dut_lsb(DATA_W) +: DATA_W]   = bus.douta;
        rsp_word[rsp_addr_lsb(DATA_W) +: ADDR_W]  = pipe_addr[RD_LAT];
        rsp_word[rsp_mis_bit(ADDR_W, DATA_W)]     = mis;
    end

    // Credit: every read already in the pipe owns a FIFO slot before it is accepted.
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [CW:0]   used;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTG; i++) inflight = inflight + CW'(pipe_v[i]);
    end

    assign used                = {1'b0, fifo_count} + {1'b0, inflight};
    assign bus.gtp2core_tready = !rst && (used < (CW + 1)'(FIFO_DEPTH));

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
            bad_cmd_cnt  <= '0;
        end else if (accept && is_clr) begin
            mismatch_cnt <= '0;
            bad_cmd_cnt  <= '0;
        end else begin
            if (rsp_push && mis && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (accept && is_bad && (bad_cmd_cnt != '1)) bad_cmd_cnt <= bad_cmd_cnt + CNT_W'(1);
        end
    end

    logic [RSP_W:0] fifo_out;

    axis_rsp_fifo #(
        .WIDTH (RSP_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (core_clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data ({pipe_last[RD_LAT], rsp_word}),
        .count     (fifo_count),
        .m_tdata   (fifo_out),
        .m_tvalid  (bus.core2gtp_tvalid),
        .m_tready  (bus.core2gtp_tready)
    );

    assign bus.core2gtp_tlast = fifo_out[RSP_W];
    assign bus.core2gtp_tdata = fifo_out[RSP_W-1:0];

endmodule

// File: tb/tb_axis_memif_cmp.sv
// Bench for axis_memif_cmp: two RD_LAT=1 memories, a response scoreboard and directed scenarios.
module tb_axis_memif_cmp;
  import axis_memif_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 3;
  localparam int CMAX       = (1 << CNT_W) - 1;
  localparam int RW         = rsp_w(ADDR_W, DATA_W) + 1;

  logic             core_clk = 1'b0;
  logic             rst      = 1'b1;
  logic             mem_init = 1'b1;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] bad_cmd_cnt;

  axis_memif_cmp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axis_memif_cmp #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .core_clk     (core_clk),
    .rst          (rst),
    .bus          (bus),
    .mismatch_cnt (mismatch_cnt),
    .bad_cmd_cnt  (bad_cmd_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 core_clk = ~core_clk;

  // ---------------- memories (1-cycle read) ----------------
  logic [7:0] dut_mem [65536];
  logic [7:0] mdl_mem [65536];

  always @(posedge core_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) begin
        dut_mem[i] <= 8'h00;
        mdl_mem[i] <= 8'h00;
      end
    end else begin
      if (bus.ena) begin
        if (bus.wea) dut_mem[bus.addra] <= bus.dina;
        else bus.douta <= dut_mem[bus.addra];
      end
      if (bus.ena_model) begin
        if (bus.wea_model) mdl_mem[bus.addra_model] <= bus.dina_model;
        else bus.douta_model <= mdl_mem[bus.addra_model];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [7:0]    sh_dut [65536];
  logic [7:0]    sh_mod [65536];
  int            exp_mis = 0;
  int            exp_bad = 0;
  logic [RW-1:0] exp_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge core_clk) begin
    if (!rst && bus.core2gtp_tvalid && bus.core2gtp_tready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_w = exp_q.pop_front();
        check("rsp", 64'({bus.core2gtp_tlast, bus.core2gtp_tdata}), 64'(exp_w));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] opc, input logic [15:0] a, input logic [7:0] d,
                      input logic l);
    int  n;
    logic m;
    n = 0;
    bus.gtp2core_tdata  = {opc, a, d};
    bus.gtp2core_tlast  = l;
    bus.gtp2core_tvalid = 1'b1;
    @(negedge core_clk);
    while (!bus.gtp2core_tready && n < 400) begin
      @(negedge core_clk);
      n++;
    end
    if (!bus.gtp2core_tready) begin
      check("accept_timeout", 64'(bus.gtp2core_tready), 64'd1);
      bus.gtp2core_tvalid = 1'b0;
    end else begin
      case (opc)
        OPC_WR:  sh_dut[a] = d;
        OPC_INJ: sh_mod[a] = d;
        OPC_RD: begin
          m = (sh_dut[a] != sh_mod[a]);
          exp_q.push_back({l, 7'b0, m, a, sh_dut[a], sh_mod[a]});
          if (m && exp_mis < CMAX) exp_mis++;
        end
        OPC_CLR: begin
          exp_mis = 0;
          exp_bad = 0;
        end
        default: if (exp_bad < CMAX) exp_bad++;
      endcase
      @(posedge core_clk);
      #1;
      bus.gtp2core_tvalid = 1'b0;
      bus.gtp2core_tlast  = 1'b0;
      bus.gtp2core_tdata  = '0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge core_clk);
      n++;
    end
    @(posedge core_clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_tready"}, 64'(bus.gtp2core_tready), 64'd0);
    check({tag, "_tvalid"}, 64'(bus.core2gtp_tvalid), 64'd0);
    check({tag, "_tdata"},  64'(bus.core2gtp_tdata), 64'd0);
    check({tag, "_tlast"},  64'(bus.core2gtp_tlast), 64'd0);
    check({tag, "_port"},   64'({bus.ena, bus.wea, bus.addra, bus.dina}), 64'd0);
    check({tag, "_mport"},  64'({bus.ena_model, bus.wea_model, bus.addra_model, bus.dina_model}), 64'd0);
    check({tag, "_miscnt"}, 64'(mismatch_cnt), 64'd0);
    check({tag, "_badcnt"}, 64'(bad_cmd_cnt), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.gtp2core_tvalid = 1'b0;
    bus.gtp2core_tdata  = '0;
    bus.gtp2core_tlast  = 1'b0;
    bus.core2gtp_tready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      sh_dut[i] = 8'h00;
      sh_mod[i] = 8'h00;
    end
    repeat (3) @(posedge core_clk);
    #1 mem_init = 1'b0;
    @(negedge core_clk);
    chk_idle("reset");
    @(posedge core_clk);
    #1 rst = 1'b0;
    @(negedge core_clk);
    check("tready_after_reset", 64'(bus.gtp2core_tready), 64'd1);
    @(posedge core_clk);
    #1;

    // write then compare, with port-drive and latency checks
    send(OPC_INJ, 16'h1234, 8'hA5, 1'b0);
    check("inj_port", 64'({bus.ena, bus.ena_model, bus.wea_model, bus.addra_model, bus.dina_model}),
          64'({1'b0, 1'b1, 1'b1, 16'h1234, 8'hA5}));
    send(OPC_WR, 16'h1234, 8'hA5, 1'b0);
    check("wr_port", 64'({bus.ena, bus.wea, bus.addra, bus.dina, bus.ena_model}),
          64'({1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0}));
    send(OPC_RD, 16'h1234, 8'hFF, 1'b0);
    check("rd_port", 64'({bus.ena, bus.ena_model, bus.wea, bus.wea_model, bus.addra, bus.addra_model,
                          bus.dina, bus.dina_model}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 8'h00, 8'h00}));
    repeat (2) @(posedge core_clk);
    #1 check("rd_latency_early", 64'(bus.core2gtp_tvalid), 64'd0);
    @(posedge core_clk);
    #1 check("rd_latency_valid", 64'(bus.core2gtp_tvalid), 64'd1);
    drain("drain_wr_cmp");
    check("miscnt_match", 64'(mismatch_cnt), 64'(exp_mis));

    // mismatch
    send(OPC_INJ, 16'h0010, 8'h3C, 1'b0);
    send(OPC_WR,  16'h0010, 8'hA5, 1'b0);
    send(OPC_RD,  16'h0010, 8'h00, 1'b0);
    drain("drain_mis");
    check("miscnt_one", 64'(mismatch_cnt), 64'(exp_mis));

    // random contents, then backpressure with FIFO_DEPTH+4 reads
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(255, 0));
      send(OPC_WR, 16'h0100 + 16'(i), d, 1'b0);
      if ($urandom_range(1, 0) == 1) d = 8'($urandom_range(255, 0));
      send(OPC_INJ, 16'h0100 + 16'(i), d, 1'b0);
    end
    bus.core2gtp_tready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check("bp_credit", 64'(bus.gtp2core_tready), 64'd1);
      send(OPC_RD, 16'h0100 + 16'(i), 8'h00, 1'b0);
    end
    check("bp_full", 64'(bus.gtp2core_tready), 64'd0);
    fork
      begin
        for (int i = FIFO_DEPTH; i < FIFO_DEPTH + 4; i++)
          send(OPC_RD, 16'h0100 + 16'(i), 8'h00, 1'b0);
      end
      begin
        repeat (20) @(posedge core_clk);
        #1;
        check("bp_stall", 64'(bus.gtp2core_tready), 64'd0);
        check("bp_held", 64'(exp_q.size()), 64'(FIFO_DEPTH));
        bus.core2gtp_tready = 1'b1;
      end
    join
    drain("drain_bp");
    check("miscnt_bp", 64'(mismatch_cnt), 64'(exp_mis));

    // bad opcode, saturation, clear
    send(8'h55, 16'h0020, 8'h00, 1'b0);
    check("bad_noport", 64'({bus.ena, bus.ena_model}), 64'd0);
    send(8'h55, 16'h0021, 8'h00, 1'b0);
    check("bad_noport", 64'({bus.ena, bus.ena_model}), 64'd0);
    check("badcnt_two", 64'(bad_cmd_cnt), 64'(exp_bad));
    for (int i = 0; i < 8; i++) send(8'($urandom_range(8'h7F, 8'h04)), 16'h0, 8'h0, 1'b0);
    check("badcnt_sat", 64'(bad_cmd_cnt), 64'(CMAX));
    send(OPC_CLR, 16'h0, 8'h0, 1'b0);
    check("clr_badcnt", 64'(bad_cmd_cnt), 64'(exp_bad));
    check("clr_miscnt", 64'(mismatch_cnt), 64'(exp_mis));

    // tlast only on the third response
    send(OPC_RD, 16'h0100, 8'h0, 1'b0);
    send(OPC_RD, 16'h0101, 8'h0, 1'b0);
    send(OPC_RD, 16'h0102, 8'h0, 1'b1);
    drain("drain_tlast");

    // reset with responses queued
    bus.core2gtp_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(OPC_RD, 16'h0010, 8'h0, 1'b0);
    repeat (4) @(posedge core_clk);
    #1 rst = 1'b1;
    @(negedge core_clk);
    chk_idle("midrst");
    exp_q.delete();
    exp_mis = 0;
    exp_bad = 0;
    repeat (2) @(posedge core_clk);
    #1 rst = 1'b0;
    bus.core2gtp_tready = 1'b1;
    @(negedge core_clk);
    check("tready_after_midrst", 64'(bus.gtp2core_tready), 64'd1);
    check("tvalid_after_midrst", 64'(bus.core2gtp_tvalid), 64'd0);
    @(posedge core_clk);
    #1;
    send(OPC_RD, 16'h0010, 8'h0, 1'b1);
    drain("drain_post_rst");
    check("miscnt_post_rst", 64'(mismatch_cnt), 64'(exp_mis));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
